uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver, the receive-side counterpart of uart_tx. It shares the baud_gen oversample_tick (16x baud).
//  Synchronizes the async rx line, detects and qualifies start bits, samples each bit at mid-point,
//  checks optional parity and the stop bit, and presents each byte on a valid/ready output with error flags.
// PARAMETERS
//  OVERSAMPLE  16  oversample ticks per bit; even, >=4
//  DATA_BITS   8   data bits per frame, LSB first
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  oversample_tick in  1          1-cycle pulse at OVERSAMPLE x baud, from baud_gen
//  rx             in   1          async serial line, idle high
//  parity_en      in   1          1 = frame carries a parity bit after the data bits
//  parity_odd     in   1          1 = odd parity, 0 = even parity
//  out_valid      out  1          received byte available
//  out_ready      in   1          consumer accepts byte when out_valid & out_ready
//  out_data       out  DATA_BITS  received byte
//  parity_err     out  1          parity mismatch for the byte on out_data
//  frame_err      out  1          stop bit sampled 0 for the byte on out_data
//  overrun        out  1          1-cycle pulse: frame completed while out_valid held, new byte dropped
//  busy           out  1          receiver is inside a frame (state != IDLE)
// BEHAVIOUR
//  - rx passes through a 2-flop synchronizer (rx_s). Both flops reset to 1.
//  - All state and counter updates occur only on clk edges with oversample_tick=1. The output handshake runs every clk.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. tick_cnt counts 0..OVERSAMPLE-1, bit_cnt counts 0..DATA_BITS-1.
//  - IDLE: armed when rx_s==1 is seen. When armed and rx_s==0, go to START with tick_cnt=0.
//  - START: on tick_cnt==OVERSAMPLE/2-1, sample rx_s.
//    - rx_s==1: glitch; return to IDLE, nothing emitted.
//    - rx_s==0: latch parity_en/parity_odd for this frame, clear tick_cnt, go to DATA.
//  - DATA: each time tick_cnt wraps at OVERSAMPLE-1, shift rx_s in at MSB (result is LSB-first data).
//    After DATA_BITS samples, go to PARITY if the latched parity_en is set, else go to STOP.
//  - PARITY: sample one bit at OVERSAMPLE ticks. p_err = sample ^ (^data) ^ latched_odd.
//  - STOP: sample at OVERSAMPLE ticks (stop-bit mid-point). f_err = ~sample. Complete the frame and go to IDLE immediately.
//    IDLE is armed only if the stop sample was 1; after a break, rx_s must return high before the next start.
//  - Completion, and the cycle after the stop-bit sampling tick:
//    - if out_valid==0, or out_ready==1 in that same cycle: load out_data/parity_err/frame_err and set out_valid=1.
//    - else: keep the old byte and flags, drop the new frame, and pulse overrun for 1 cycle.
//  - out_valid drops the cycle after out_valid & out_ready, unless a completion reloads it in that cycle.
//  - out_data, parity_err and frame_err are stable while out_valid=1.
//  - Latency: out_valid rises 1 clk after the stop-bit mid-point tick.
//  - Reset values: out_valid=0, out_data=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counters=0.
//    Reset mid-frame discards the partial frame.
//  - parity_en/parity_odd changes during a frame have no effect until the next start bit.
// TESTING  (clk 50 MHz, baud_gen 115200, out_ready=1 unless noted)
//  1. Drive 8'h41, even parity (parity bit 0), stop 1 -> one out_valid pulse, out_data=8'h41, parity_err=0, frame_err=0.
//  2. Loopback from uart_tx, 8'h55 then 8'hA3 back-to-back, parity off -> two beats in order (55, A3), no overrun, no errors.
//  3. Drive 8'h41 with even parity but parity bit 1 -> out_data=8'h41, parity_err=1. Same byte with parity_odd=1 and bit 1 -> parity_err=0.
//  4. Stop bit 0, then rx held low for 20 bit times, then a valid 8'h7E -> first beat frame_err=1. Exactly one more beat follows: 8'h7E, clean.
//  5. rx low for 4 oversample ticks only -> busy asserts then clears before the mid-start tick. No out_valid.
//  6. out_ready=0, send 8'h11 then 8'h22 -> out_data stays 8'h11, one overrun pulse.
//     Then assert reset mid-way through a third frame -> busy=0, out_valid=0; the next frame 8'h33 is received clean.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchronizer, mid-bit sampling at OVERSAMPLE x baud,
// optional parity, stop-bit check and a valid/ready output with error flags.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 oversample_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   frame_perr_q, frame_perr_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   done;
    logic                   done_ferr;

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        armed_d      = armed_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        frame_perr_d = frame_perr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        done         = 1'b0;
        done_ferr    = 1'b0;

        if (oversample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d    = 1'b0;
                        tick_cnt_d = '0;
                        state_d    = START;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            par_en_d     = parity_en;
                            par_odd_d    = parity_odd;
                            frame_perr_d = 1'b0;
                            bit_cnt_d    = '0;
                            state_d      = DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        frame_perr_d = rx_s_q ^ (^shift_q) ^ par_odd_q;
                        state_d      = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        done       = 1'b1;
                        done_ferr  = ~rx_s_q;
                        // a low stop sample (break) must see the line high again before re-arming
                        armed_d    = rx_s_q;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d  = 1'b1;
                out_data_d   = shift_q;
                parity_err_d = frame_perr_q;
                frame_err_d  = done_ferr;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            frame_perr_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            frame_perr_q <= frame_perr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, expected beats queued
// at send time and compared by a monitor on every out_valid & out_ready.
module tb_uart_rx;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned BIT_CLKS   = OVERSAMPLE * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       oversample_tick = 1'b0;
    logic       rx;
    logic       parity_en;
    logic       parity_odd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    beats = 0;
    int    overrun_cnt = 0;
    int    beats_mark;

    uart_rx #(.OVERSAMPLE(OVERSAMPLE), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .oversample_tick(oversample_tick),
        .rx(rx),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            cyc(TICK_DIV - 1);
            oversample_tick = 1'b1;
            cyc(1);
            oversample_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (overrun === 1'b1) overrun_cnt++;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input bit par_on, input logic par_bit,
                              input logic stop_bit);
        rx = 1'b0;
        cyc(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            cyc(BIT_CLKS);
        end
        if (par_on) begin
            rx = par_bit;
            cyc(BIT_CLKS);
        end
        rx = stop_bit;
        cyc(BIT_CLKS);
    endtask

    function automatic beat_t mk(input logic [7:0] d, input bit par_on, input logic par_bit,
                                 input logic odd, input logic stop_bit);
        beat_t b;
        b.data = d;
        b.perr = par_on ? (par_bit != ((^d) ^ odd)) : 1'b0;
        b.ferr = ~stop_bit;
        return b;
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 4 * BIT_CLKS) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        out_ready = 1'b1;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        cyc(4);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cyc(2 * BIT_CLKS);

        // 1: 0x41 even parity, correct parity bit
        parity_en = 1'b1;
        parity_odd = 1'b0;
        sb.push_back(mk(8'h41, 1'b1, 1'b0, 1'b0, 1'b1));
        send_frame(8'h41, 1'b1, 1'b0, 1'b1);
        wait_drain("t1_drain");

        // 2: back-to-back, parity off
        parity_en = 1'b0;
        sb.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        sb.push_back(mk(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
        wait_drain("t2_drain");
        check("t2_overrun", 32'(overrun_cnt), 32'd0);

        // 3: wrong even parity, then odd parity with bit 1
        parity_en = 1'b1;
        parity_odd = 1'b0;
        sb.push_back(mk(8'h41, 1'b1, 1'b1, 1'b0, 1'b1));
        send_frame(8'h41, 1'b1, 1'b1, 1'b1);
        wait_drain("t3a_drain");
        parity_odd = 1'b1;
        sb.push_back(mk(8'h41, 1'b1, 1'b1, 1'b1, 1'b1));
        send_frame(8'h41, 1'b1, 1'b1, 1'b1);
        wait_drain("t3b_drain");

        // 4: stop bit 0, break of 20 bit times, then a clean frame
        parity_en = 1'b0;
        parity_odd = 1'b0;
        beats_mark = beats;
        sb.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        cyc(20 * BIT_CLKS);
        rx = 1'b1;
        cyc(2 * BIT_CLKS);
        sb.push_back(mk(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        wait_drain("t4_drain");
        cyc(2 * BIT_CLKS);
        check("t4_beats", 32'(beats - beats_mark), 32'd2);

        // 5: short glitch on rx
        beats_mark = beats;
        rx = 1'b0;
        cyc(4 * TICK_DIV);
        check("t5_busy_set", 32'(busy), 32'd1);
        rx = 1'b1;
        cyc(12 * TICK_DIV);
        check("t5_busy_clr", 32'(busy), 32'd0);
        cyc(2 * BIT_CLKS);
        check("t5_beats", 32'(beats - beats_mark), 32'd0);

        // 6: consumer stalled, second frame dropped with overrun
        out_ready = 1'b0;
        sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        cyc(BIT_CLKS);
        check("t6_valid_held", 32'(out_valid), 32'd1);
        check("t6_data_held", 32'(out_data), 32'h11);
        check("t6_overrun", 32'(overrun_cnt), 32'd1);
        out_ready = 1'b1;
        wait_drain("t6_drain");

        // reset in the middle of a third frame
        rx = 1'b0;
        cyc(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            cyc(BIT_CLKS);
        end
        rx = 1'b1;
        reset = 1'b1;
        cyc(3);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        cyc(2 * BIT_CLKS);
        sb.push_back(mk(8'h33, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        wait_drain("t6_final_drain");
        cyc(BIT_CLKS);
        check("total_overrun", 32'(overrun_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
